edge_synchronizer: RTL and testbench

EDGE_SYNCHRONIZER -- requirements
Module: edge_synchronizer

---
 rtl/edge_synchronizer_pkg.sv | 15 +
 rtl/sync_glitch_filter.sv | 62 ++++++
 rtl/edge_synchronizer.sv | 79 +++++++
 tb/tb_edge_synchronizer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/edge_synchronizer_pkg.sv
// Shared bounds and helpers for the edge synchronizer.
// Glitch filter is enabled by defining SYNC_GLITCH_FILTER_EN.
package edge_synchronizer_pkg;

   localparam int SYNC_STAGES_MIN   = 2;
   localparam int SYNC_STAGES_MAX   = 4;
   localparam int FILTER_CYCLES_MIN = 1;
   localparam int FILTER_CYCLES_MAX = 255;

   // Counter must hold 0..FILTER_CYCLES-1 with headroom.
   function automatic int cnt_width(input int fc);
      return $clog2(fc + 1);
   endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// Per-channel glitch filter: stability counter and out flop.
// Built only with SYNC_GLITCH_FILTER_EN; otherwise a wire.
module sync_glitch_filter
   import edge_synchronizer_pkg::*;
#(
   parameter int   FILTER_CYCLES = 4,
   parameter logic RESET_BIT     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_i,
   output logic out_o
);

`ifdef SYNC_GLITCH_FILTER_EN

   localparam int CW = cnt_width(FILTER_CYCLES);
   localparam logic [CW-1:0] CNT_LAST =
      CW'(FILTER_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          out_q;
   logic          out_d;

   // Count while the synced bit disagrees; toggle on the last.
   always_comb begin
      cnt_d = '0;
      out_d = out_q;
      if (sync_i != out_q) begin
         if (cnt_q == CNT_LAST) begin
            out_d = sync_i;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Counter and filtered level; reset drops any partial count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         out_q <= RESET_BIT;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

`else

   logic unused_filter;

   assign unused_filter = clk ^ reset_n ^
                          (FILTER_CYCLES == 0);
   assign out_o = sync_i;

`endif

endmodule

// File: rtl/edge_synchronizer.sv
// Multi-bit level synchronizer with rise/fall/change pulses.
// Glitch filter is enabled by defining SYNC_GLITCH_FILTER_EN.
module edge_synchronizer
   import edge_synchronizer_pkg::*;
#(
   parameter int DATA_WIDTH    = 1,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out,
   output logic [DATA_WIDTH-1:0] rise,
   output logic [DATA_WIDTH-1:0] fall,
   output logic                  any_change
);

   if (SYNC_STAGES < SYNC_STAGES_MIN ||
       SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $fatal(1, "SYNC_STAGES out of range 2..4");
   end

   if (FILTER_CYCLES < FILTER_CYCLES_MIN ||
       FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filt
      $fatal(1, "FILTER_CYCLES out of range 1..255");
   end

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_d;
   logic [DATA_WIDTH-1:0]                  prev_q;
   logic [DATA_WIDTH-1:0]                  prev_d;

   // Shift chain: stage 0 is the only flop sampling in.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in};
   end

   // Synchronizer flops; every stage resets to RESET_VALUE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
         sync_q <= sync_d;
      end
   end

   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_ch
      sync_glitch_filter #(
         .FILTER_CYCLES (FILTER_CYCLES),
         .RESET_BIT     (RESET_VALUE[g])
      ) u_filt (
         .clk     (clk),
         .reset_n (reset_n),
         .sync_i  (sync_q[SYNC_STAGES-1][g]),
         .out_o   (out[g])
      );
   end

   // Previous out level; reset matches out so release is silent.
   always_comb begin
      prev_d = out;
   end

   // Delayed copy of out for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= RESET_VALUE;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise       = out & ~prev_q;
   assign fall       = ~out & prev_q;
   assign any_change = |(out ^ prev_q);

endmodule

// File: tb/tb_edge_synchronizer.sv
// Directed bench for edge_synchronizer (3 stages, filter 4).
// Expectations follow SYNC_GLITCH_FILTER_EN when defined.
module tb_edge_synchronizer;

`ifdef SYNC_GLITCH_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif
   localparam int L = FILT ? 7 : 3;

   logic       clk;
   logic       reset_n;
   logic [1:0] in_a, out_a, rise_a, fall_a;
   logic [1:0] in_b, out_b, rise_b, fall_b;
   logic       any_a, any_b;
   int         tests;
   int         fails;

   edge_synchronizer #(
      .DATA_WIDTH    (2),
      .SYNC_STAGES   (3),
      .FILTER_CYCLES (4),
      .RESET_VALUE   (2'b00)
   ) dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .in         (in_a),
      .out        (out_a),
      .rise       (rise_a),
      .fall       (fall_a),
      .any_change (any_a)
   );

   edge_synchronizer #(
      .DATA_WIDTH    (2),
      .SYNC_STAGES   (3),
      .FILTER_CYCLES (4),
      .RESET_VALUE   (2'b01)
   ) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .in         (in_b),
      .out        (out_b),
      .rise       (rise_b),
      .fall       (fall_b),
      .any_change (any_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [1:0] obs,
                      input logic [1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b",
                tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic e1;
      tests   = 0;
      fails   = 0;
      reset_n = 1'b0;
      in_a    = 2'b00;
      in_b    = 2'b00;
      repeat (3) @(negedge clk);

      chk("rst out_a", out_a, 2'b00);
      chk("rst pulses_a", rise_a | fall_a, 2'b00);
      chk("rst any_a", {1'b0, any_a}, 2'b00);
      chk("rst out_b", out_b, 2'b01);
      chk("rst pulses_b", rise_b | fall_b, 2'b00);

      // release with in_b differing from its reset value
      reset_n = 1'b1;
      for (int k = 1; k <= L + 1; k++) begin
         step(1);
         chk("rel out_b", out_b,
             (k >= L) ? 2'b00 : 2'b01);
         chk("rel fall_b", fall_b,
             (k == L) ? 2'b01 : 2'b00);
         chk("rel rise_b", rise_b, 2'b00);
         chk("rel any_b", {1'b0, any_b},
             {1'b0, k == L});
         chk("rel any_a", {1'b0, any_a}, 2'b00);
      end

      // single rising edge on channel 0
      in_a = 2'b01;
      for (int k = 1; k <= L + 1; k++) begin
         step(1);
         chk("r0 out", out_a,
             (k >= L) ? 2'b01 : 2'b00);
         chk("r0 rise", rise_a,
             (k == L) ? 2'b01 : 2'b00);
         chk("r0 fall", fall_a, 2'b00);
         chk("r0 any", {1'b0, any_a},
             {1'b0, k == L});
      end

      // 3-cycle pulse on channel 1
      in_a = 2'b11;
      for (int k = 1; k <= L + 4; k++) begin
         step(1);
         e1 = !FILT && k >= 3 && k <= 5;
         chk("gl out", out_a, {e1, 1'b1});
         chk("gl rise", rise_a,
             {!FILT && k == 3, 1'b0});
         chk("gl fall", fall_a,
             {!FILT && k == 6, 1'b0});
         if (k == 3) in_a = 2'b01;
      end

      // both channels rise together
      in_a = 2'b00;
      step(L + 2);
      chk("pre2 out", out_a, 2'b00);
      in_a = 2'b11;
      for (int k = 1; k <= L + 1; k++) begin
         step(1);
         chk("r2 out", out_a,
             (k >= L) ? 2'b11 : 2'b00);
         chk("r2 rise", rise_a,
             (k == L) ? 2'b11 : 2'b00);
         chk("r2 any", {1'b0, any_a},
             {1'b0, k == L});
      end

      // reset in the middle of a counted transition
      in_a = 2'b00;
      step(L + 2);
      chk("pre3 out", out_a, 2'b00);
      in_a = 2'b01;
      step(5);
      reset_n = 1'b0;
      #1;
      chk("ar out_a", out_a, 2'b00);
      chk("ar rise_a", rise_a, 2'b00);
      chk("ar any_a", {1'b0, any_a}, 2'b00);
      chk("ar out_b", out_b, 2'b01);
      step(2);
      reset_n = 1'b1;
      for (int k = 1; k <= L + 1; k++) begin
         step(1);
         chk("rs out_a", out_a,
             (k >= L) ? 2'b01 : 2'b00);
         chk("rs rise_a", rise_a,
             (k == L) ? 2'b01 : 2'b00);
         chk("rs fall_b", fall_b,
             (k == L) ? 2'b01 : 2'b00);
      end

      // channel 1 toggling every cycle
      in_a = 2'b11;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         e1 = !FILT && k >= 3 && ((k - 3) % 2 == 0);
         chk("tg out", out_a, {e1, 1'b1});
         in_a[1] = ~in_a[1];
      end

      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule
